// File: rtl/timer_event_capture.sv
// timer_event_capture
//   Timestamps rising edges of an upstream timer interrupt into a small FIFO
//   and exposes the captured values, status and an event counter over a
//   16-bit Avalon-MM slave.
//
// Ports
//   clk         sole clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   timer_irq   level interrupt from the upstream interval timer
//   address     word address (0 status, 1 control, 2/3 head timestamp,
//               4/5 event count; writes: 0 clear overflow, 1 control,
//               4 pop, 5 clear event count)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one cycle latency
//   irq         capture-pending interrupt (irq_en && FIFO not empty)
module timer_event_capture #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_irq,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   ts_q, ts_d;
    logic          irq_d_q;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   evcnt_q, evcnt_d;
    logic [15:0]   readdata_q, readdata_d;
    logic          irq_q, irq_d;

    logic wr, wr_clr_ovf, wr_ctrl, wr_pop, wr_clr_cnt;
    logic rise, evt, empty, full, pop, push, drop;
    logic [31:0] head;
    logic [15:0] count_ext;

    assign wr         = chipselect && !write_n;
    assign wr_clr_ovf = wr && (address == 3'd0);
    assign wr_ctrl    = wr && (address == 3'd1);
    assign wr_pop     = wr && (address == 3'd4);
    assign wr_clr_cnt = wr && (address == 3'd5);

    assign rise  = timer_irq && !irq_d_q;
    assign evt   = rise && ctrl_q[0];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop frees the slot the same-cycle event needs, so a full FIFO
    // with a pop accepts the push instead of dropping it.
    assign pop  = wr_pop && !empty;
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    assign head      = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign count_ext = 16'(count_q);

    always_comb begin
        ts_d       = ts_q + 32'd1;
        ctrl_d     = wr_ctrl ? writedata[1:0] : ctrl_q;
        wr_ptr_d   = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        // Set has priority over a same-cycle clear.
        ovf_d      = (ovf_q && !wr_clr_ovf) || drop;

        evcnt_d    = evcnt_q;
        if (wr_clr_cnt) begin
            evcnt_d = evt ? 32'd1 : 32'd0;
        end else if (evt && (evcnt_q != 32'hFFFF_FFFF)) begin
            evcnt_d = evcnt_q + 32'd1;
        end

        readdata_d = 16'd0;
        case (address)
            3'd0:    readdata_d = {8'b0, count_ext[3:0], 1'b0, ovf_q, full, empty};
            3'd1:    readdata_d = {14'b0, ctrl_q};
            3'd2:    readdata_d = head[15:0];
            3'd3:    readdata_d = head[31:16];
            3'd4:    readdata_d = evcnt_q[15:0];
            3'd5:    readdata_d = evcnt_q[31:16];
            default: readdata_d = 16'd0;
        endcase

        // Reflects post-update state so irq rises the cycle after a push.
        irq_d      = ctrl_d[1] && (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q       <= '0;
            irq_d_q    <= 1'b0;
            ctrl_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            evcnt_q    <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            irq_d_q    <= timer_irq;
            ctrl_q     <= ctrl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            evcnt_q    <= evcnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset: the head read is gated by empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_timer_event_capture.sv
// Testbench for timer_event_capture: queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_timer_event_capture;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timer_irq = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    timer_event_capture #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .timer_irq  (timer_irq),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_q[$];
    logic [31:0] m_ts = 0;
    logic        m_irqd = 0;
    logic [1:0]  m_ctrl = 0;
    logic        m_ovf = 0;
    logic [31:0] m_ev = 0;
    logic [15:0] m_rd = 0;
    logic        m_irq = 0;

    always begin : model
        logic        w, ev;
        logic [31:0] hd;
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_ts = 0; m_irqd = 0; m_ctrl = 0; m_ovf = 0; m_ev = 0;
            m_rd = 0; m_irq = 0;
        end else begin
            hd = (m_q.size() > 0) ? m_q[0] : 32'd0;
            case (address)
                3'd0: m_rd = {8'b0, 4'(m_q.size()), 1'b0, m_ovf,
                              m_q.size() == DEPTH, m_q.size() == 0};
                3'd1: m_rd = {14'b0, m_ctrl};
                3'd2: m_rd = hd[15:0];
                3'd3: m_rd = hd[31:16];
                3'd4: m_rd = m_ev[15:0];
                3'd5: m_rd = m_ev[31:16];
                default: m_rd = 16'd0;
            endcase
            w  = chipselect && !write_n;
            ev = timer_irq && !m_irqd && m_ctrl[0];
            if (w && address == 3'd4 && m_q.size() > 0) void'(m_q.pop_front());
            if (w && address == 3'd0) m_ovf = 1'b0;
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else m_ovf = 1'b1;
            end
            if (w && address == 3'd5) m_ev = 0;
            if (ev && m_ev != 32'hFFFF_FFFF) m_ev = m_ev + 1;
            if (w && address == 3'd1) m_ctrl = writedata[1:0];
            m_irqd = timer_irq;
            m_ts   = m_ts + 1;
            m_irq  = m_ctrl[1] && (m_q.size() > 0);
        end
    end

    always begin : compare
        @(negedge clk);
        if (chk_en) begin
            vectors++;
            if (readdata !== m_rd) begin
                miscompares++;
                $display("FAIL readdata @%0t: got %h expected %h", $time, readdata, m_rd);
            end
            vectors++;
            if (irq !== m_irq) begin
                miscompares++;
                $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; timer_irq = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
        @(negedge clk);
        address = a;
        @(negedge clk);
        check(nm, 32'(readdata), 32'(exp));
        check({nm, "_model"}, 32'(m_rd), 32'(exp));
    endtask

    task automatic pulse();
        @(negedge clk);
        timer_irq = 1'b1;
        @(negedge clk);
        timer_irq = 1'b0;
    endtask

    task automatic pulse_with_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        timer_irq = 1'b1; address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        timer_irq = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Single capture at timestamp 0x64
        do_reset();
        chk_en = 1'b1;
        rd_chk("reset_status", 3'd0, 16'h0001);
        do_reset();
        wr_reg(3'd1, 16'h0003);
        repeat (97) @(negedge clk);
        pulse();
        check("irq_after_push", 32'(irq), 32'd1);
        rd_chk("one_status", 3'd0, 16'h0010);
        rd_chk("one_ts_lo", 3'd2, 16'h0064);
        rd_chk("one_ts_hi", 3'd3, 16'h0000);
        rd_chk("one_ctrl", 3'd1, 16'h0003);

        // Nine events into an 8-deep FIFO; events at timestamps 3,5,..,19
        do_reset();
        wr_reg(3'd1, 16'h0003);
        for (int i = 0; i < 9; i++) pulse();
        rd_chk("ovf_status", 3'd0, 16'h0086);
        rd_chk("ovf_evcnt_lo", 3'd4, 16'd9);
        rd_chk("ovf_evcnt_hi", 3'd5, 16'd0);
        for (int i = 0; i < 8; i++) begin
            rd_chk("pop_order", 3'd2, 16'(3 + 2 * i));
            wr_reg(3'd4, 16'h0000);
        end
        rd_chk("drained_status", 3'd0, 16'h0005);
        check("irq_drained", 32'(irq), 32'd0);
        wr_reg(3'd4, 16'h0000);
        rd_chk("pop_empty_status", 3'd0, 16'h0005);
        wr_reg(3'd0, 16'hFFFF);
        rd_chk("ovf_cleared", 3'd0, 16'h0001);

        // Full FIFO with event and pop in the same cycle
        do_reset();
        wr_reg(3'd1, 16'h0001);
        for (int i = 0; i < 8; i++) pulse();
        pulse_with_write(3'd4, 16'h0000);
        rd_chk("full_pop_push_status", 3'd0, 16'h0082);
        for (int i = 0; i < 7; i++) begin
            rd_chk("full_pop_order", 3'd2, 16'(5 + 2 * i));
            wr_reg(3'd4, 16'h0000);
        end
        rd_chk("newest_at_tail", 3'd2, 16'd19);
        wr_reg(3'd4, 16'h0000);
        pulse_with_write(3'd4, 16'h0000);
        rd_chk("empty_pop_push_status", 3'd0, 16'h0010);

        // Held level gives one event; disabled edges are not counted
        do_reset();
        wr_reg(3'd1, 16'h0001);
        @(negedge clk);
        timer_irq = 1'b1;
        repeat (50) @(negedge clk);
        timer_irq = 1'b0;
        rd_chk("held_evcnt", 3'd4, 16'd1);
        wr_reg(3'd1, 16'h0000);
        for (int i = 0; i < 3; i++) pulse();
        rd_chk("disabled_evcnt", 3'd4, 16'd1);
        rd_chk("disabled_status", 3'd0, 16'h0010);
        rd_chk("disabled_head", 3'd2, 16'd3);
        wr_reg(3'd4, 16'h0000);
        rd_chk("disabled_popped", 3'd0, 16'h0001);

        // Event count clear collides with an event
        wr_reg(3'd1, 16'h0001);
        pulse();
        pulse();
        rd_chk("pre_clear_evcnt", 3'd4, 16'd3);
        pulse_with_write(3'd5, 16'h0000);
        rd_chk("clear_with_event", 3'd4, 16'd1);
        rd_chk("clear_with_event_hi", 3'd5, 16'd0);

        // Reset mid-operation with a colliding write and held timer_irq
        do_reset();
        wr_reg(3'd1, 16'h0003);
        for (int i = 0; i < 5; i++) pulse();
        rd_chk("five_status", 3'd0, 16'h0050);
        @(negedge clk);
        reset = 1'b1; timer_irq = 1'b1;
        address = 3'd1; writedata = 16'h0003; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        check("rst_readdata", 32'(readdata), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        @(negedge clk);
        check("post_rst_status", 32'(readdata), 32'h0001);
        rd_chk("post_rst_ctrl", 3'd1, 16'h0000);
        rd_chk("post_rst_evcnt", 3'd4, 16'h0000);
        timer_irq = 1'b0;
        rd_chk("post_rst_unused", 3'd6, 16'h0000);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
